// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Recovers pixel coordinates from an asynchronous hSync/vSync pair, checks
// the stream against fixed 640x480 timing and reports lock state.
// Optional error counter: define VGA_SYNC_DECODER_ERRCNT_EN to build errCount;
// without it errCount is tied to zero.
// The timing parameters default to the 640x480 values and are only
// overridden for scaled-down simulation.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned H_ACTIVE_START = 144,
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned V_TOTAL        = 525,
  parameter int unsigned V_ACTIVE_START = 35,
  parameter int unsigned V_ACTIVE       = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixEn,
  input  logic       hSync,
  input  logic       vSync,
  output logic       locked,
  output logic       active,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       frameStart,
  output logic [7:0] errCount
);

  localparam logic [9:0] CNT_MAX  = 10'd1023;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_LO = 10'(H_ACTIVE_START);
  localparam logic [9:0] H_ACT_HI = 10'(H_ACTIVE_START + H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_LO = 10'(V_ACTIVE_START);
  localparam logic [9:0] V_ACT_HI = 10'(V_ACTIVE_START + V_ACTIVE - 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  logic       hs_meta_q, hs_sync_q, vs_meta_q, vs_sync_q;
  logic       hs_prev_q, vs_prev_q;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       pend_q, pend_d;
  state_t     state_q, state_d;
  logic       acq_err_q, acq_err_d;
  logic       locked_q, active_q, frame_start_q;
  logic [9:0] x_q;
  logic [8:0] y_q;

  logic h_fall, v_fall, boundary;
  logic line_mis, frame_mis, timeout, err_evt;
  logic act_d;

  // Two-flop synchronizers; idle level of both syncs is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_meta_q <= 1'b1;
      hs_sync_q <= 1'b1;
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
    end else begin
      hs_meta_q <= hSync;
      hs_sync_q <= hs_meta_q;
      vs_meta_q <= vSync;
      vs_sync_q <= vs_meta_q;
    end
  end

  // Previous pixel-rate sample, used for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else if (pixEn) begin
      hs_prev_q <= hs_sync_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  // A vFall in the same sample as the hFall also opens the frame boundary
  assign h_fall    = pixEn & hs_prev_q & ~hs_sync_q;
  assign v_fall    = pixEn & vs_prev_q & ~vs_sync_q;
  assign boundary  = h_fall & (pend_q | v_fall);
  assign line_mis  = h_fall & (hcount_q != H_LAST);
  assign frame_mis = boundary & (vcount_q != V_LAST);
  // Timeout fires only on the step into 1023, so it counts once per stall
  assign timeout   = pixEn & ~h_fall & (hcount_q == CNT_MAX - 10'd1);
  assign err_evt   = line_mis | frame_mis | timeout;

  // Next-state for the pixel/line counters and the pending-vsync flag
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    pend_d   = pend_q;
    if (pixEn) begin
      if (h_fall) begin
        hcount_d = '0;
      end else if (hcount_q != CNT_MAX) begin
        hcount_d = hcount_q + 10'd1;
      end
      if (boundary) begin
        vcount_d = '0;
        pend_d   = 1'b0;
      end else begin
        if (h_fall && (vcount_q != CNT_MAX)) begin
          vcount_d = vcount_q + 10'd1;
        end
        if (v_fall) begin
          pend_d = 1'b1;
        end
      end
    end
  end

  // Counter and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      pend_q   <= pend_d;
    end
  end

  // Lock FSM next-state; ACQUIRE remembers whether its current frame was clean
  always_comb begin
    state_d   = state_q;
    acq_err_d = acq_err_q;
    case (state_q)
      SEARCH: begin
        if (boundary) begin
          state_d   = ACQUIRE;
          acq_err_d = 1'b0;
        end
      end
      ACQUIRE: begin
        if (boundary) begin
          if (!acq_err_q && !err_evt) begin
            state_d = LOCKED;
          end
          acq_err_d = 1'b0;
        end else if (err_evt) begin
          acq_err_d = 1'b1;
        end
      end
      LOCKED: begin
        if (err_evt) begin
          state_d = SEARCH;
        end
      end
      default: begin
        state_d   = SEARCH;
        acq_err_d = 1'b0;
      end
    endcase
  end

  // Lock FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      acq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acq_err_q <= acq_err_d;
    end
  end

  assign act_d = (state_d == LOCKED) &&
                 (hcount_d >= H_ACT_LO) && (hcount_d <= H_ACT_HI) &&
                 (vcount_d >= V_ACT_LO) && (vcount_d <= V_ACT_HI);

  // Registered outputs, built from the values the counters/FSM move to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q      <= 1'b0;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      locked_q      <= (state_d == LOCKED);
      active_q      <= act_d;
      x_q           <= act_d ? (hcount_d - H_ACT_LO) : '0;
      y_q           <= act_d ? 9'(vcount_d - V_ACT_LO) : '0;
      frame_start_q <= boundary & (state_d == LOCKED);
    end
  end

  assign locked     = locked_q;
  assign active     = active_q;
  assign x          = x_q;
  assign y          = y_q;
  assign frameStart = frame_start_q;

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // One count per pixel sample with any event while tracking; saturates
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt && (state_q != SEARCH) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign errCount = err_cnt_q;
`else
  assign errCount = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using scaled-down timing (12 x 8 total,
// 6 x 4 visible) so that hundreds of frames fit in a short run.
module tb_vga_sync_decoder;
  localparam int HT = 12, HAS = 4, HA = 6;
  localparam int VT = 8,  VAS = 2, VA = 4;

  logic       clk = 1'b0;
  logic       reset, pixEn, hSync, vSync;
  logic       locked, active, frameStart;
  logic [9:0] x;
  logic [8:0] y;
  logic [7:0] errCount;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_ACTIVE_START(HAS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_ACTIVE_START(VAS), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .reset(reset), .pixEn(pixEn), .hSync(hSync), .vSync(vSync),
    .locked(locked), .active(active), .x(x), .y(y),
    .frameStart(frameStart), .errCount(errCount)
  );

  always #5 clk = ~clk;

  int  n_chk = 0, n_fail = 0;
  int  per_lo, per_hi;
  bit  model_on;
  bit  vs_tail;
  int  fs_clks = 0;
  bit  sat_phase = 0, lock_seen = 0, err_seen = 0;

  always @(negedge clk) begin
    if (frameStart === 1'b1) fs_clks++;
    if (sat_phase && locked === 1'b1) lock_seen = 1;
    if (errCount !== 8'd0) err_seen = 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {2'b0, locked, active, x, y, frameStart, errCount};
  endfunction

  function automatic int err_exp(input int n);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  // ---------------- reference model (one step per pixel sample) ----------
  // Horizontal position is the distance in samples from the last hFall.
  int m_idx, m_last, m_lines, m_mode, m_err, m_fs = 0;
  bit m_pend, m_phs, m_pvs, m_bad;

  function automatic void model_reset();
    m_idx = 0; m_last = 0; m_lines = 0; m_mode = 0; m_err = 0;
    m_pend = 0; m_phs = 1; m_pvs = 1; m_bad = 0;
  endfunction

  function automatic logic [31:0] model_step(input bit hs, input bit vs);
    int dist_old, hc, vc;
    bit hf, vf, bnd, err, lk, ac, fs;
    dist_old = m_idx - m_last;
    m_idx++;
    hf = m_phs && !hs;
    vf = m_pvs && !vs;
    m_phs = hs; m_pvs = vs;
    bnd = hf && (m_pend || vf);
    err = (hf && dist_old != HT - 1) || (bnd && m_lines != VT - 1) ||
          (!hf && (m_idx - m_last) == 1023);
    if (hf) begin
      m_last = m_idx;
      m_lines = bnd ? 0 : (m_lines < 1023 ? m_lines + 1 : 1023);
    end
    if (bnd) m_pend = 0;
    else if (vf) m_pend = 1;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    if (err && m_mode != 0 && m_err < 255) m_err++;
`endif
    if (m_mode == 0) begin
      if (bnd) begin m_mode = 1; m_bad = 0; end
    end else if (m_mode == 1) begin
      if (bnd) begin
        if (!m_bad && !err) m_mode = 2;
        m_bad = 0;
      end else if (err) m_bad = 1;
    end else if (err) m_mode = 0;
    hc = (m_idx - m_last > 1023) ? 1023 : m_idx - m_last;
    vc = m_lines;
    lk = (m_mode == 2);
    ac = lk && hc >= HAS && hc < HAS + HA && vc >= VAS && vc < VAS + VA;
    fs = bnd && lk;
    if (fs) m_fs++;
    return {2'b0, lk, ac, ac ? 10'(hc - HAS) : 10'd0, ac ? 9'(vc - VAS) : 9'd0,
            fs, 8'(m_err)};
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick(input bit pe);
    pixEn = pe;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input bit hs, input bit vs);
    int per;
    hSync = hs;
    vSync = vs;
    per = int'($urandom_range(per_lo, per_hi));
    repeat (per - 1) tick(1'b0);
    tick(1'b1);
    if (model_on) check("pixel", dut_vec(), model_step(hs, vs));
  endtask

  // vSync falls mid-way through the last line and rises mid-way through the
  // first line of the following frame.
  task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                            input bit chk, input int rst_line);
    int len;
    bit hs, vs;
    for (int l = 0; l < nlines; l++) begin
      len = (l == bad_line) ? bad_len : HT;
      for (int p = 0; p < len; p++) begin
        hs = (p >= 2);
        vs = !((l == nlines - 1 && p >= len / 2) || (l == 0 && p < HT / 2 && vs_tail));
        send_pixel(hs, vs);
        if (chk && l == 0 && p == 0) begin
          check("lock_frame_start", {30'd0, locked, frameStart}, 32'd3);
          tick(1'b0);
          check("frame_start_width", {31'd0, frameStart}, 32'd0);
        end
        if (chk && l == VAS && p == HAS)
          check("first_pixel", {2'b0, active, x, y, 11'd0}, {2'b0, 1'b1, 10'd0, 9'd0, 11'd0});
        if (chk && l == VAS + VA - 1 && p == HAS + HA - 1)
          check("last_pixel", {2'b0, active, x, y, 11'd0},
                {2'b0, 1'b1, 10'(HA - 1), 9'(VA - 1), 11'd0});
        if (l == rst_line && p == HAS + 1) begin
          check("pre_reset_active", {31'd0, active}, 32'd1);
          reset = 1'b1;
          #1;
          check("async_reset", dut_vec(), 32'd0);
          repeat (3) tick(1'b0);
          reset = 1'b0;
          model_reset();
        end
      end
    end
    vs_tail = 1;
  endtask

  typedef struct {
    int nlines;
    int bad_line;
    int bad_len;
    bit chk;
    bit exp_locked;
    int exp_err;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{8, -1, 12, 0, 0, 0};
    tbl[1]  = '{8, -1, 12, 0, 0, 0};
    tbl[2]  = '{8, -1, 12, 1, 1, 0};
    tbl[3]  = '{8,  3, 11, 0, 0, 1};
    tbl[4]  = '{8, -1, 12, 0, 0, 1};
    tbl[5]  = '{8, -1, 12, 0, 1, 1};
    tbl[6]  = '{7, -1, 12, 0, 1, 1};
    tbl[7]  = '{8, -1, 12, 0, 0, 2};
    tbl[8]  = '{8, -1, 12, 0, 0, 2};
    tbl[9]  = '{8,  5, 13, 0, 0, 3};
    tbl[10] = '{8, -1, 12, 0, 0, 3};
    tbl[11] = '{8, -1, 12, 0, 1, 3};
    tbl[12] = '{8,  2, 11, 0, 0, 4};
    tbl[13] = '{8,  1, 11, 0, 0, 5};
    tbl[14] = '{8, -1, 12, 0, 0, 5};
    tbl[15] = '{8, -1, 12, 0, 1, 5};

    reset = 1'b1; pixEn = 1'b0; hSync = 1'b1; vSync = 1'b1;
    per_lo = 4; per_hi = 4; model_on = 1; vs_tail = 0;
    model_reset();
    repeat (3) tick(1'b0);
    check("reset_state", dut_vec(), 32'd0);
    reset = 1'b0;

    // Frame-level table: lock, loss and reacquisition
    for (int i = 0; i < 16; i++) begin
      send_frame(tbl[i].nlines, tbl[i].bad_line, tbl[i].bad_len, tbl[i].chk, -1);
      check($sformatf("row%0d_locked", i), {31'd0, locked}, {31'd0, tbl[i].exp_locked});
      check($sformatf("row%0d_err", i), {24'd0, errCount}, 32'(err_exp(tbl[i].exp_err)));
    end

    // Reset in the visible area of line 3, then relock two boundaries later
    send_frame(VT, -1, HT, 0, 3);
    send_frame(VT, -1, HT, 0, -1);
    check("relock_b1", {31'd0, locked}, 32'd0);
    send_frame(VT, -1, HT, 0, -1);
    check("relock_b2", {31'd0, locked}, 32'd1);
    check("relock_err", {24'd0, errCount}, 32'd0);

    // hSync stuck high: lock drops on the sample that takes hCount to 1023
    for (int i = 0; i < 1100; i++) begin
      send_pixel(1'b1, 1'b1);
      if (i == 1010) check("timeout_before", {31'd0, locked}, 32'd1);
      if (i == 1011) begin
        check("timeout_drop", {31'd0, locked}, 32'd0);
        check("timeout_err", {24'd0, errCount}, 32'(err_exp(1)));
      end
    end
    check("timeout_err_once", {24'd0, errCount}, 32'(err_exp(1)));
    vs_tail = 0;
    send_frame(VT, -1, HT, 0, -1);
    send_frame(VT, -1, HT, 0, -1);
    check("timeout_relock", {31'd0, locked}, 32'd1);

    // Randomized frames with jittered pixEn spacing
    per_lo = 3; per_hi = 6;
    for (int f = 0; f < 20; f++) begin
      int r, nl, bl, blen;
      r = int'($urandom_range(0, 9));
      nl = VT; bl = -1; blen = HT;
      if (r == 0) begin
        bl = int'($urandom_range(0, VT - 1));
        blen = ($urandom_range(0, 1) == 1) ? HT - 1 : HT + 1;
      end else if (r == 1) begin
        nl = ($urandom_range(0, 1) == 1) ? VT - 1 : VT + 1;
      end
      send_frame(nl, bl, blen, 0, -1);
    end
    check("frame_start_clks", fs_clks, m_fs);

    // Short frames at full pixel rate: counter saturates, lock never forms
    reset = 1'b1;
    repeat (2) tick(1'b0);
    reset = 1'b0;
    model_on = 0; per_lo = 1; per_hi = 1; vs_tail = 0;
    sat_phase = 1;
    for (int f = 0; f < 270; f++) send_frame(VT - 1, -1, HT, 0, -1);
    tick(1'b0);
    sat_phase = 0;
    check("sat_never_locked", {31'd0, lock_seen}, 32'd0);
    check("sat_err", {24'd0, errCount}, 32'(err_exp(255)));
`ifndef VGA_SYNC_DECODER_ERRCNT_EN
    check("err_always_zero", {31'd0, err_seen}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  100 MHz system clock.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 pixEn  input  1  one-clk strobe per pixel (every 4th clk at 25 MHz pixel rate); all counting occurs only on pixEn cycles.
REQ-005 hSync  input  1  active-low horizontal sync from the display timing source; asynchronous to clk.
REQ-006 vSync  input  1  active-low vertical sync; asynchronous to clk.
REQ-007 locked  output  1  high while the decoder is tracking a valid 640x480 stream.
REQ-008 active  output  1  high while the current pixel is inside the 640x480 visible area and locked=1.
REQ-009 x  output  10  visible column 0..639; 0 when active=0.
REQ-010 y  output  9  visible row 0..479; 0 when active=0.
REQ-011 frameStart  output  1  one-clk pulse at each frame boundary while locked.
REQ-012 errCount  output  8  saturating count of timing mismatches.

Function
REQ-013 Timing constants: H_TOTAL=800, H_ACTIVE_START=144 (96 sync + 48 back porch), H_ACTIVE=640; V_TOTAL=525, V_ACTIVE_START=35 (2 sync + 33 back porch), V_ACTIVE=480.
REQ-014 hSync and vSync SHALL each pass through a 2-flop synchronizer clocked every clk.
REQ-015 hFall/vFall SHALL be detected on pixEn cycles as the synchronized signal going high→low between consecutive pixEn samples.
REQ-016 hCount (10 bit): on pixEn, cleared to 0 on hFall, else incremented, saturating at 1023.
REQ-017 vCount (10 bit): incremented on each hFall; a vFall sets a pending flag, and the first hFall with the flag set clears vCount to 0 and clears the flag (this is the frame boundary).
REQ-018 Line mismatch: hFall with hCount≠799. Frame mismatch: frame boundary with vCount≠524. Line timeout: hCount reaches 1023.
REQ-019 FSM states SEARCH, ACQUIRE, LOCKED; SEARCH→ACQUIRE at a frame boundary.
REQ-020 ACQUIRE→LOCKED at the next frame boundary if no mismatch or timeout occurred since entering ACQUIRE; otherwise ACQUIRE SHALL stay in ACQUIRE and restart its check from that boundary.
REQ-021 LOCKED→SEARCH on any mismatch or timeout.
REQ-022 locked = (state==LOCKED).
REQ-023 active SHALL be high iff locked, 144≤hCount≤783 and 35≤vCount≤514.
REQ-024 x = hCount−144 and y = vCount−35 when active, else 0.
REQ-025 locked, active, x, y and frameStart SHALL be registered and update one clk after the pixEn cycle that changes hCount or vCount.
REQ-026 frameStart SHALL pulse for exactly one clk per frame boundary while in LOCKED, including the boundary that causes ACQUIRE→LOCKED.
REQ-027 errCount SHALL increment by 1 per pixEn cycle in ACQUIRE or LOCKED holding one or more mismatch/timeout events (simultaneous events count once), saturating at 255.
REQ-028 Timeout is counted once, when hCount first reaches 1023.

Reset
REQ-029 reset SHALL asynchronously force state=SEARCH, all counters and the pending flag to 0, synchronizer flops to 1, and all outputs to 0.
REQ-030 reset asserted mid-frame SHALL force the outputs low immediately, and reacquisition SHALL follow REQ-019/020.

Configuration
REQ-031 With macro VGA_SYNC_DECODER_ERRCNT_EN defined, errCount SHALL behave per REQ-027; without it, the counter logic SHALL be absent and errCount SHALL be tied to 0.

Verification
REQ-032 Nominal stream, pixEn every 4th clk → locked rises at the 2nd frame boundary with frameStart pulsed; at line 35, hCount 144: active=1, x=0, y=0; at line 514, hCount 783: x=639, y=479.
REQ-033 While locked, inject one 799-pixel line → locked=0 one clk after the hFall and errCount=1; after two further good frame boundaries, locked=1 again.
REQ-034 While locked, hold hSync high for 1100 pixels → locked drops when hCount reaches 1023, and errCount increments once.
REQ-035 Assert reset at line 200 → all outputs are 0 without waiting for a clk edge, and relock occurs at the 2nd frame boundary after release.
REQ-036 Feed 300 frames of 524 lines → errCount saturates at 255 and locked never rises; with the macro undefined, errCount=0 throughout.
